pid_sequencer: RTL and testbench

Initiator side of the PID controller's `start_calc`/`done` handshake.

- On each control sample tick it:
  - computes the sign-magnitude error `setpoint - measurement`;
  - presents the error to the PID core and pulses `start_calc`;
  - waits for `done`, with a timeout.
- It then scales and saturates the PID result into a signed actuator command for the motor-mixing stage.
- It sits between the sensor/setpoint registers and the PID core in the flight-control loop.

---
 rtl/pid_pkg.sv | 31 +++
 rtl/pid_sequencer_sm_sub32.sv | 34 +++
 rtl/pid_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pid_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID sequencer.
//   sm32_t      : 32-bit sign-magnitude word (sign, 31-bit magnitude)
//   state_t     : sequencer FSM states
//   SM_MAG_MAX  : largest representable sign-magnitude magnitude
//   sm_to_twos  : sign-magnitude to 33-bit two's complement
package pid_pkg;

   localparam int unsigned SM_MAG_W = 31;
   localparam logic [SM_MAG_W-1:0] SM_MAG_MAX = '1;

   typedef struct packed {
      logic                sign;
      logic [SM_MAG_W-1:0] mag;
   } sm32_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_SCALE = 3'd4
   } state_t;

   // Negative zero maps to 0 naturally, so no special case is needed.
   function automatic logic signed [32:0] sm_to_twos(input sm32_t v);
      logic signed [32:0] m;
      m = $signed({2'b00, v.mag});
      return v.sign ? -m : m;
   endfunction

endpackage

// File: rtl/pid_sequencer_sm_sub32.sv
// Combinational sign-magnitude subtract diff_c = a - b.
//   a, b   : sign-magnitude operands (negative zero accepted as +0)
//   diff_c : sign-magnitude result, magnitude saturated to SM_MAG_MAX,
//            zero always emitted with sign 0
module sm_sub32
   import pid_pkg::*;
(
   input  sm32_t a,
   input  sm32_t b,
   output sm32_t diff_c
);

   logic signed [32:0] a_t;
   logic signed [32:0] b_t;
   logic [33:0]        d;
   logic [33:0]        mag_u;
   logic               neg;

   // Subtract in two's complement with one guard bit, then convert back.
   always_comb begin
      a_t   = sm_to_twos(a);
      b_t   = sm_to_twos(b);
      d     = {a_t[32], a_t} - {b_t[32], b_t};
      neg   = d[33];
      mag_u = neg ? (~d + 34'd1) : d;
      diff_c.sign = neg;
      if (mag_u > {3'b000, SM_MAG_MAX}) begin
         diff_c.mag = SM_MAG_MAX;
      end else begin
         diff_c.mag = mag_u[30:0];
      end
   end

endmodule

// File: rtl/pid_sequencer.sv
// Initiator side of the PID core start_calc/done handshake.
// On each accepted sample tick it forms setpoint - measurement, starts the
// PID core, waits (with timeout) for done, then scales and saturates the
// PID result into a signed actuator command.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : gates sample_tick in IDLE
//   sample_tick     : one-cycle iteration request
//   setpoint        : sign-magnitude setpoint
//   measurement     : sign-magnitude measurement
//   clear_err       : clears timeout_err
//   error           : sign-magnitude error to the PID core
//   start_calc      : one-cycle start pulse to the PID core
//   done, pid_out   : PID core completion and sign-magnitude result
//   cmd_out         : two's-complement actuator command
//   cmd_valid       : one-cycle pulse when cmd_out updates
//   cmd_sat         : current cmd_out was clamped
//   busy            : FSM not in IDLE
//   timeout_err     : sticky timeout flag
//   overrun_cnt     : saturating count of dropped ticks
module pid_sequencer
   import pid_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned OUT_SHIFT      = 8,
   parameter int unsigned CMD_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sample_tick,
   input  logic [31:0]      setpoint,
   input  logic [31:0]      measurement,
   input  logic             clear_err,
   output logic [31:0]      error,
   output logic             start_calc,
   input  logic             done,
   input  logic [31:0]      pid_out,
   output logic [CMD_W-1:0] cmd_out,
   output logic             cmd_valid,
   output logic             cmd_sat,
   output logic             busy,
   output logic             timeout_err,
   output logic [7:0]       overrun_cnt
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam int unsigned MAG_W = CMD_W - 1;
   localparam logic [30:0] CMD_MAX = 31'((64'd1 << MAG_W) - 64'd1);

   state_t            state;
   state_t            state_next;
   sm32_t             sp_q;
   sm32_t             meas_q;
   sm32_t             pid_q;
   sm32_t             diff_c;
   logic [CNT_W-1:0]  cnt;

   logic              latch_op;
   logic              load_err;
   logic              clr_cnt;
   logic              inc_cnt;
   logic              cap_pid;
   logic              load_cmd;
   logic              set_to;

   logic [30:0]       shifted_c;
   logic              sat_c;
   logic [CMD_W-1:0]  mag_c;
   logic [CMD_W-1:0]  cmd_c;

   sm_sub32 u_err_sub (
      .a      (sp_q),
      .b      (meas_q),
      .diff_c (diff_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_next = state;
      latch_op   = 1'b0;
      load_err   = 1'b0;
      clr_cnt    = 1'b0;
      inc_cnt    = 1'b0;
      cap_pid    = 1'b0;
      load_cmd   = 1'b0;
      set_to     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (sample_tick && en) begin
               latch_op   = 1'b1;
               state_next = S_CALC;
            end
         end
         S_CALC: begin
            load_err   = 1'b1;
            state_next = S_START;
         end
         S_START: begin
            clr_cnt    = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            // done takes priority over an expiring timeout
            if (done) begin
               cap_pid    = 1'b1;
               state_next = S_SCALE;
            end else if (cnt == CNT_LAST) begin
               set_to     = 1'b1;
               state_next = S_IDLE;
            end else begin
               inc_cnt = 1'b1;
            end
         end
         S_SCALE: begin
            load_cmd   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Scale and clamp the captured PID result; range is kept symmetric.
   always_comb begin
      shifted_c = pid_q.mag >> OUT_SHIFT;
      sat_c     = shifted_c > CMD_MAX;
      mag_c     = sat_c ? CMD_W'(CMD_MAX) : CMD_W'(shifted_c);
      cmd_c     = pid_q.sign ? (~mag_c + CMD_W'(1)) : mag_c;
   end

   assign busy = (state != S_IDLE);

   // Datapath and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q        <= '0;
         meas_q      <= '0;
         pid_q       <= '0;
         error       <= '0;
         start_calc  <= 1'b0;
         cnt         <= '0;
         cmd_out     <= '0;
         cmd_valid   <= 1'b0;
         cmd_sat     <= 1'b0;
         timeout_err <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (latch_op) begin
            sp_q   <= setpoint;
            meas_q <= measurement;
         end
         if (load_err) begin
            error <= diff_c;
         end
         start_calc <= (state_next == S_START);
         if (clr_cnt) begin
            cnt <= '0;
         end else if (inc_cnt) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (cap_pid) begin
            pid_q <= pid_out;
         end
         cmd_valid <= load_cmd;
         if (load_cmd) begin
            cmd_out <= cmd_c;
            cmd_sat <= sat_c;
         end
         // a timeout in the same cycle as clear_err leaves the flag set
         if (set_to) begin
            timeout_err <= 1'b1;
         end else if (clear_err) begin
            timeout_err <= 1'b0;
         end
         if (sample_tick && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed self-checking bench for pid_sequencer.
module tb_pid_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        sample_tick;
   logic [31:0] setpoint;
   logic [31:0] measurement;
   logic        clear_err;
   logic [31:0] error;
   logic        start_calc;
   logic        done;
   logic [31:0] pid_out;
   logic [15:0] cmd_out;
   logic        cmd_valid;
   logic        cmd_sat;
   logic        busy;
   logic        timeout_err;
   logic [7:0]  overrun_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pid_sequencer #(
      .TIMEOUT_CYCLES (64),
      .OUT_SHIFT      (8),
      .CMD_W          (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sample_tick (sample_tick),
      .setpoint    (setpoint),
      .measurement (measurement),
      .clear_err   (clear_err),
      .error       (error),
      .start_calc  (start_calc),
      .done        (done),
      .pid_out     (pid_out),
      .cmd_out     (cmd_out),
      .cmd_valid   (cmd_valid),
      .cmd_sat     (cmd_sat),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun_cnt (overrun_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Tick at edge N, check CALC/START timing, leave DUT in WAIT.
   task automatic start_txn(input logic [31:0] sp, input logic [31:0] ms, input logic [31:0] exp_err);
      setpoint    = sp;
      measurement = ms;
      en          = 1'b1;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      setpoint    = 32'h1234_5678;
      measurement = 32'h8765_4321;
      check_eq("busy_calc", 32'(busy), 32'd1);
      check_eq("start_early", 32'(start_calc), 32'd0);
      step();
      check_eq("error", error, exp_err);
      check_eq("start_pulse", 32'(start_calc), 32'd1);
      step();
      check_eq("start_end", 32'(start_calc), 32'd0);
      check_eq("busy_wait", 32'(busy), 32'd1);
   endtask

   // Hold done low for wait_cyc WAIT cycles, then complete with po.
   task automatic finish_txn(input int wait_cyc, input logic [31:0] po,
                             input logic [15:0] exp_cmd, input logic exp_sat);
      repeat (wait_cyc) step();
      done    = 1'b1;
      pid_out = po;
      step();
      done    = 1'b0;
      pid_out = 32'h0;
      check_eq("busy_scale", 32'(busy), 32'd1);
      check_eq("valid_early", 32'(cmd_valid), 32'd0);
      step();
      check_eq("cmd_valid", 32'(cmd_valid), 32'd1);
      check_eq("cmd_out", 32'(cmd_out), 32'(exp_cmd));
      check_eq("cmd_sat", 32'(cmd_sat), 32'(exp_sat));
      check_eq("busy_idle", 32'(busy), 32'd0);
      step();
      check_eq("valid_end", 32'(cmd_valid), 32'd0);
      check_eq("cmd_hold", 32'(cmd_out), 32'(exp_cmd));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_error"}, error, 32'd0);
      check_eq({tag, "_start"}, 32'(start_calc), 32'd0);
      check_eq({tag, "_cmd"}, 32'(cmd_out), 32'd0);
      check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd0);
      check_eq({tag, "_sat"}, 32'(cmd_sat), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_terr"}, 32'(timeout_err), 32'd0);
      check_eq({tag, "_ovr"}, 32'(overrun_cnt), 32'd0);
   endtask

   initial begin
      logic seen_valid;
      rst = 1'b1; en = 1'b0; sample_tick = 1'b0; setpoint = '0;
      measurement = '0; clear_err = 1'b0; done = 1'b0; pid_out = '0;
      step(); step();
      rst = 1'b0;
      step();
      check_all_zero("reset");

      // tick with en low is ignored
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check_eq("en_low_busy", 32'(busy), 32'd0);
      check_eq("en_low_ovr", 32'(overrun_cnt), 32'd0);

      // zero error; {1,25600} >> 8 = -100
      start_txn(32'd5000, 32'd5000, 32'h0000_0000);
      finish_txn(4, 32'h8000_6400, 16'hFF9C, 1'b0);

      // +1000 - (-2000) = +3000; 0x01000000 >> 8 clamps to 32767
      start_txn(32'd1000, 32'h8000_07D0, 32'h0000_0BB8);
      finish_txn(0, 32'h0100_0000, 16'h7FFF, 1'b1);

      // 0 - 700000 = {1,700000}; 0x1234 >> 8 = 18
      start_txn(32'd0, 32'd700000, 32'h800A_AE60);
      finish_txn(2, 32'h0000_1234, 16'h0012, 1'b0);

      // -0 - +0 = +0; max negative magnitude clamps to -32767
      start_txn(32'h8000_0000, 32'd0, 32'h0000_0000);
      finish_txn(1, 32'hFFFF_FFFF, 16'h8001, 1'b1);

      // magnitude saturation, then timeout with done held low
      start_txn(32'h7FFF_FFFF, 32'h8000_0005, 32'h7FFF_FFFF);
      seen_valid = 1'b0;
      repeat (63) begin
         step();
         if (cmd_valid) seen_valid = 1'b1;
      end
      check_eq("to_busy_63", 32'(busy), 32'd1);
      check_eq("to_terr_63", 32'(timeout_err), 32'd0);
      step();
      if (cmd_valid) seen_valid = 1'b1;
      check_eq("to_terr", 32'(timeout_err), 32'd1);
      check_eq("to_busy", 32'(busy), 32'd0);
      check_eq("to_no_valid", 32'(seen_valid), 32'd0);
      check_eq("to_cmd_hold", 32'(cmd_out), 32'h0000_8001);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      check_eq("clear_err", 32'(timeout_err), 32'd0);

      // timeout coinciding with clear_err: set wins
      start_txn(32'd10, 32'd3, 32'h0000_0007);
      repeat (63) step();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      check_eq("to_set_wins", 32'(timeout_err), 32'd1);
      check_eq("to_set_busy", 32'(busy), 32'd0);

      // overrun: three ticks during WAIT, then reset mid-WAIT
      start_txn(32'd100, 32'd40, 32'h0000_003C);
      repeat (3) begin
         sample_tick = 1'b1;
         step();
         sample_tick = 1'b0;
         step();
      end
      check_eq("overrun", 32'(overrun_cnt), 32'd3);
      check_eq("overrun_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      step();
      rst = 1'b0;
      step();

      // clean transaction after reset: -300 - (-1000) = +700
      start_txn(32'h8000_012C, 32'h8000_03E8, 32'h0000_02BC);
      finish_txn(3, 32'h0001_2345, 16'h0123, 1'b0);
      check_eq("post_ovr", 32'(overrun_cnt), 32'd0);
      check_eq("post_terr", 32'(timeout_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
